// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART peripheral.
//   arb_state_t      : arbiter FSM states (ARB, ISSUE, WAIT_DONE, GAP)
//   BYTE_W           : width of one UART data byte
//   CLKS_PER_BIT_DEF : default system clocks per bit (100 MHz / 9600 baud)
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 10417;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin index selection.
//   valid_i [N-1:0]     : request vector
//   last_i  [IDX_W-1:0] : index served most recently
//   any_o               : at least one request present
//   sel_o   [IDX_W-1:0] : first valid index searching last+1, last+2, ... mod N
// Generic on purpose so other peripheral arbiters can reuse it.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] sel_o
);

  // Walk the search order backwards so the last hit written is the
  // highest-priority one; avoids a break and keeps the loop static.
  always_comb begin
    sel_o = '0;
    any_o = |valid_i;
    for (int i = N; i >= 1; i--) begin
      if (valid_i[(int'(last_i) + i) % N]) begin
        sel_o = IDX_W'((int'(last_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte requesters.
// Round-robin arbitration, one byte in flight at a time, watchdog on the
// transmitter's done pulse.
//
// Ports:
//   clk_i, reset_i       : system clock, synchronous active-high reset
//   req_valid_i/data_i   : per-requester byte pending and its byte
//   req_ready_o          : one-cycle accept pulse, coincident with tx_dv_o
//   grant_o              : one-hot owner of the byte in flight, 0 when idle
//   tx_dv_o / tx_byte_o  : one-cycle start pulse and byte to transmitter
//   tx_active_i          : transmitter busy (consistency check only)
//   tx_done_i            : transmitter completion pulse
//   busy_o               : arbiter not in ARB
//   err_o / err_clr_i    : sticky watchdog-timeout flag and its clear
//   req_lock_i           : only with UART_ARB_LOCK_EN; owner keeps the
//                          transmitter while lock and valid stay high
//
// Build option: define UART_ARB_LOCK_EN to add req_lock_i and message locking.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ARB       | idle, picking the next requester
// ISSUE     | tx_dv_o/req_ready_o high this cycle, watchdog restarts
// WAIT_DONE | byte in flight, counting toward TIMEOUT_CYCLES
// GAP       | transmitter post-done cleanup cycle; grant dropped on exit
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CYCLES = 11 * CLKS_PER_BIT + 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      tx_dv_o,
  output logic [BYTE_W-1:0]         tx_byte_o,
  input  logic                      tx_active_i,
  input  logic                      tx_done_i,
  output logic                      busy_o,
  output logic                      err_o,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock_i,
`endif
  input  logic                      err_clr_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              dv_q, dv_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_sel;
  logic [IDX_W-1:0]  sel_idx;
  logic [BYTE_W-1:0] sel_byte;
  logic              relock;
  logic              timeout;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .any_o   (pick_any),
    .sel_o   (pick_sel)
  );

  // A done pulse in the expiry cycle counts as done, so err is not raised.
  assign timeout = (state_q == WAIT_DONE) && !tx_done_i && (wd_q >= WD_LAST);

`ifdef UART_ARB_LOCK_EN
  // lock_ok_q drops on a timeout so a hung owner cannot keep re-grabbing
  // the transmitter; any later grant re-arms it.
  logic lock_ok_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_ok_q <= 1'b0;
    end else if (state_q == ARB && pick_any) begin
      lock_ok_q <= 1'b1;
    end else if (timeout) begin
      lock_ok_q <= 1'b0;
    end
  end

  assign relock = lock_ok_q && req_lock_i[last_q] && req_valid_i[last_q];
`else
  assign relock = 1'b0;
`endif

  assign sel_idx  = relock ? last_q : pick_sel;
  assign sel_byte = req_data_i[int'(sel_idx)*BYTE_W +: BYTE_W];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ready_d = '0;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    wd_d    = wd_q;
    err_d   = err_q;

    unique case (state_q)
      ARB: begin
        if (pick_any) begin
          grant_d = N_REQ'(1) << sel_idx;
          ready_d = N_REQ'(1) << sel_idx;
          byte_d  = sel_byte;
          dv_d    = 1'b1;
          last_d  = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The ISSUE cycle itself is the first cycle after the start pulse,
        // so the count restarts at 1 and reaches TIMEOUT_CYCLES on the
        // edge exactly TIMEOUT_CYCLES cycles after tx_dv_o.
        wd_d    = WD_W'(1);
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          state_d = GAP;
        end else if (timeout) begin
          state_d = GAP;
        end
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase

    // Set beats clear when both land in the same cycle.
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      ready_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign grant_o     = grant_q;
  assign tx_dv_o     = dv_q;
  assign tx_byte_o   = byte_q;
  assign busy_o      = (state_q != ARB);
  assign err_o       = err_q;

  // The transmitter must be idle whenever a start pulse goes out; a
  // still-active transmitter would silently drop the byte.
  a_tx_idle_on_start: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (state_q == ISSUE) |-> !tx_active_i
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int CPB     = 4;
  localparam int TIMEOUT = 60;
  localparam int TX_LEN  = 10 * CPB;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [3:0]   req_valid_i = '0;
  logic [31:0]  req_data_i = '0;
  logic [3:0]   req_ready_o;
  logic [3:0]   grant_o;
  logic         tx_dv_o;
  logic [7:0]   tx_byte_o;
  logic         tx_active_i;
  logic         tx_done_i;
  logic         busy_o;
  logic         err_o;
  logic         err_clr_i = 1'b0;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]   req_lock_i = '0;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  bit tx_hang = 1'b0;
  int tx_cnt = 0;

  uart_tx_arbiter #(
    .N_REQ          (N_REQ),
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_dv_o     (tx_dv_o),
    .tx_byte_o   (tx_byte_o),
    .tx_active_i (tx_active_i),
    .tx_done_i   (tx_done_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
`ifdef UART_ARB_LOCK_EN
    .req_lock_i  (req_lock_i),
`endif
    .err_clr_i   (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural transmitter: busy for TX_LEN cycles after a start pulse,
  // then a one-cycle done. With tx_hang set it ignores start pulses.
  always @(posedge clk_i) begin
    if (reset_i) begin
      tx_active_i <= 1'b0;
      tx_done_i   <= 1'b0;
      tx_cnt      <= 0;
    end else begin
      tx_done_i <= 1'b0;
      if (tx_active_i) begin
        if (tx_cnt == 1) begin
          tx_active_i <= 1'b0;
          tx_done_i   <= 1'b1;
        end
        tx_cnt <= tx_cnt - 1;
      end else if (tx_dv_o && !tx_hang) begin
        tx_active_i <= 1'b1;
        tx_cnt      <= TX_LEN;
      end
    end
  end

  always @(posedge clk_i) begin
    if (tx_done_i) last_done_cyc <= cyc;
    cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic wait_dv(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk_i);
      waited++;
      if (tx_dv_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    err_clr_i = 1'b0;
    tx_hang = 1'b0;
`ifdef UART_ARB_LOCK_EN
    req_lock_i = '0;
`endif
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (grant_o !== 4'b0) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
    tests_run++; if (req_ready_o !== 4'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
    tests_run++; if (tx_dv_o !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %b want 0", tx_dv_o); end
    tests_run++; if (tx_byte_o !== 8'h00) begin tests_failed++; $display("FAIL reset_byte: got %h want 00", tx_byte_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_o); end
  endtask

  task automatic test_single();
    bit ok; int waited;
    do_reset();
    req_data_i[7:0] = 8'h55;
    req_valid_i = 4'b0001;
    wait_dv(20, ok, waited);
    tests_run++; if (!ok || waited != 1) begin tests_failed++; $display("FAIL single_latency: got ok=%0d cycles=%0d want ok=1 cycles=1", ok, waited); end
    tests_run++; if (tx_byte_o !== 8'h55) begin tests_failed++; $display("FAIL single_byte: got %h want 55", tx_byte_o); end
    tests_run++; if (req_ready_o !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %b want 0001", req_ready_o); end
    tests_run++; if (grant_o !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b want 0001", grant_o); end
    req_valid_i = 4'b0000;
    @(negedge clk_i);
    tests_run++; if (tx_dv_o !== 1'b0 || req_ready_o !== 4'b0) begin tests_failed++; $display("FAIL single_pulse_width: got dv=%b ready=%b want 0/0000", tx_dv_o, req_ready_o); end
    repeat (10) @(negedge clk_i);
    tests_run++; if (grant_o !== 4'b0001 || busy_o !== 1'b1) begin tests_failed++; $display("FAIL single_grant_hold: got grant=%b busy=%b want 0001/1", grant_o, busy_o); end
    wait_idle(100, ok);
    tests_run++; if (!ok || grant_o !== 4'b0) begin tests_failed++; $display("FAIL single_release: got idle=%0d grant=%b want 1/0000", ok, grant_o); end
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b want 0", err_o); end
  endtask

  task automatic test_round_robin();
    bit ok; int waited; int gap;
    logic [7:0] exp_byte;
    logic [3:0] exp_oh;
    do_reset();
    req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_byte = 8'hA0 + 8'(i % 4);
      exp_oh = 4'b0001 << (i % 4);
      wait_dv(200, ok, waited);
      gap = cyc - last_done_cyc;
      if (i == 4) req_valid_i = 4'b0000;
      tests_run++; if (!ok || tx_byte_o !== exp_byte) begin tests_failed++; $display("FAIL rr_byte%0d: got ok=%0d byte=%h want %h", i, ok, tx_byte_o, exp_byte); end
      tests_run++; if (req_ready_o !== exp_oh || grant_o !== exp_oh) begin tests_failed++; $display("FAIL rr_onehot%0d: got ready=%b grant=%b want %b", i, req_ready_o, grant_o, exp_oh); end
      if (i > 0) begin
        tests_run++; if (gap !== 3) begin tests_failed++; $display("FAIL rr_gap%0d: got %0d cycles from done to dv, want 3", i, gap); end
      end
    end
    wait_idle(200, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_idle: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_timeout();
    bit ok; int waited; int dv_cyc; bit seen;
    do_reset();
    tx_hang = 1'b1;
    req_data_i[23:16] = 8'h77;
    req_valid_i = 4'b0100;
    wait_dv(20, ok, waited);
    dv_cyc = cyc;
    req_valid_i = 4'b0000;
    tests_run++; if (!ok || tx_byte_o !== 8'h77) begin tests_failed++; $display("FAIL to_dv: got ok=%0d byte=%h want 77", ok, tx_byte_o); end
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_i);
      if (err_o === 1'b1) seen = 1'b1;
    end
    tests_run++; if (!seen || (cyc - dv_cyc) !== TIMEOUT) begin tests_failed++; $display("FAIL to_latency: got seen=%0d cycles=%0d want 60", seen, cyc - dv_cyc); end
    @(negedge clk_i);
    tests_run++; if (busy_o !== 1'b0 || grant_o !== 4'b0) begin tests_failed++; $display("FAIL to_recover: got busy=%b grant=%b want 0/0000", busy_o, grant_o); end
    tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL to_sticky: got %b want 1", err_o); end
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL to_clear: got %b want 0", err_o); end
    tx_hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int waited;
    do_reset();
    req_data_i[15:8] = 8'h22;
    req_valid_i = 4'b0010;
    wait_dv(20, ok, waited);
    req_valid_i = 4'b0000;
    repeat (5) @(negedge clk_i);
    tests_run++; if (!ok || busy_o !== 1'b1) begin tests_failed++; $display("FAIL mid_inflight: got ok=%0d busy=%b want 1/1", ok, busy_o); end
    reset_i = 1'b1;
    @(negedge clk_i);
    tests_run++; if (grant_o !== 4'b0 || tx_dv_o !== 1'b0 || req_ready_o !== 4'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || tx_byte_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got grant=%b dv=%b ready=%b busy=%b err=%b byte=%h want all 0", grant_o, tx_dv_o, req_ready_o, busy_o, err_o, tx_byte_o);
    end
    reset_i = 1'b0;
    req_data_i = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    req_valid_i = 4'b1111;
    wait_dv(20, ok, waited);
    req_valid_i = 4'b0000;
    tests_run++; if (!ok || tx_byte_o !== 8'hC0 || req_ready_o !== 4'b0001) begin tests_failed++; $display("FAIL mid_first_after: got ok=%0d byte=%h ready=%b want C0/0001", ok, tx_byte_o, req_ready_o); end
    wait_idle(200, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mid_idle: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_drop();
    bit ok; int waited; int extra;
    do_reset();
    req_data_i = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    req_valid_i = 4'b0101;
    wait_dv(20, ok, waited);
    tests_run++; if (!ok || tx_byte_o !== 8'hB0) begin tests_failed++; $display("FAIL drop_first: got ok=%0d byte=%h want B0", ok, tx_byte_o); end
    req_valid_i = 4'b1000;
    wait_dv(200, ok, waited);
    req_valid_i = 4'b0000;
    tests_run++; if (!ok || tx_byte_o !== 8'hB3 || req_ready_o !== 4'b1000) begin tests_failed++; $display("FAIL drop_next: got ok=%0d byte=%h ready=%b want B3/1000", ok, tx_byte_o, req_ready_o); end
    extra = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk_i);
      if (tx_dv_o === 1'b1) extra++;
    end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL drop_no_extra: got %0d extra pulses want 0", extra); end
    tests_run++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin tests_failed++; $display("FAIL drop_idle: got busy=%b err=%b want 0/0", busy_o, err_o); end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    bit ok; int waited;
    logic [7:0] exp_b [4] = '{8'hD0, 8'hD1, 8'hD2, 8'hE3};
    do_reset();
    req_data_i = {8'hE3, 8'h00, 8'hD0, 8'h00};
    req_lock_i = 4'b0010;
    req_valid_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_dv(200, ok, waited);
      tests_run++; if (!ok || tx_byte_o !== exp_b[i]) begin tests_failed++; $display("FAIL lock_byte%0d: got ok=%0d byte=%h want %h", i, ok, tx_byte_o, exp_b[i]); end
      if (i < 2) begin
        req_data_i[15:8] = exp_b[i+1];
      end else if (i == 2) begin
        req_valid_i[1] = 1'b0;
        req_lock_i[1] = 1'b0;
      end else begin
        req_valid_i = 4'b0000;
      end
    end
    wait_idle(200, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL lock_idle: got busy=%b want 0", busy_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_drop();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
